// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the EX-stage pipeline controller: forward selects,
// multi-cycle sequencer states and the load result-source code.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_e;

    // MEM beats WB so the youngest producer wins; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear, used for the
// stall/flush performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + ONE;
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use / branch hazard
// resolution and sequencing of a multi-cycle multiply occupying EX.
module ex_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MulE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MulGo,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // Cycle 0 is spent in IDLE issuing MulGo, the final cycle in BUSY lets
    // the op advance, so BUSY holds for MUL_LAT-2 further stall cycles.
    localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 2);

    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd;

    assign rs_e = {Rs2E, Rs1E};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        assign fwd[i] = fwd_sel(rs_e[i], RdM, RegWriteM, RdW, RegWriteW);
    end

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    logic lw_stall;
    assign lw_stall = (ResultSrcE0 == RESULTSRC_LOAD[0]) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    mul_state_e state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        MulGo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MulE) begin
                    MulGo     = 1'b1;
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    StallE    = 1'b1;
                    FlushM    = 1'b1;
                    state_nxt = ST_BUSY;
                    cnt_nxt   = MUL_LOAD;
                end else begin
                    // A taken branch discards the dependent instruction, so it overrides the load stall.
                    StallF = lw_stall && !PCSrcE;
                    StallD = lw_stall && !PCSrcE;
                    FlushE = lw_stall || PCSrcE;
                    FlushD = PCSrcE;
                end
            end
            ST_BUSY: begin
                // The op in EX can never be killed here, so branch and load hazards wait for IDLE.
                if (cnt != 8'd0) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    FlushM  = 1'b1;
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign MulBusy = (state == ST_BUSY);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallF),
        .cnt   (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (PCSrcE),
        .cnt   (FlushCnt)
    );

endmodule
